// File: rtl/tetris_playfield.sv
// Tetris playfield grid: lock commits 4 cells, full rows flash for FLASH_FRAMES ticks then compact (ROWS cycles).
// lock_ready only in IDLE; requester holds lock_valid. `GARBAGE_EN adds a 1-cycle garbage-row insert on the same handshake.
module tetris_playfield #(
    parameter int COLS         = 10,
    parameter int ROWS         = 20,
    parameter int CW           = 3,
    parameter int FLASH_FRAMES = 3,
    parameter int XW           = $clog2(COLS),
    parameter int YW           = $clog2(ROWS)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_tick,
    input  logic              lock_valid,
    output logic              lock_ready,
    input  logic [4*XW-1:0]   lock_x,
    input  logic [4*YW-1:0]   lock_y,
    input  logic [CW-1:0]     lock_color,
    input  logic [4*XW-1:0]   probe_x,
    input  logic [4*YW-1:0]   probe_y,
    output logic              probe_ok,
    input  logic [XW-1:0]     rd_x,
    input  logic [YW-1:0]     rd_y,
    output logic [CW-1:0]     rd_color,
    output logic [ROWS-1:0]   flash_row,
    output logic              busy,
    output logic              done,
    output logic [2:0]        lines,
`ifdef GARBAGE_EN
    input  logic              garbage_valid,
    input  logic [XW-1:0]     garbage_hole,
    input  logic [CW-1:0]     garbage_color,
    output logic              top_out,
`endif
    output logic [15:0]       total_lines
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_SCAN    = 3'd1;
    localparam logic [2:0] ST_FLASH   = 3'd2;
    localparam logic [2:0] ST_COMPACT = 3'd3;

    logic [CW-1:0]   cells_q [ROWS][COLS];
    logic [CW-1:0]   cells_d [ROWS][COLS];
    logic [2:0]      state_q, state_d;
    logic [ROWS-1:0] flash_row_q, flash_row_d;
    logic [3:0]      tick_cnt_q, tick_cnt_d;
    logic [YW-1:0]   dst_q, dst_d;
    logic [YW-1:0]   src_q, src_d;
    logic            src_end_q, src_end_d;
    logic            done_q, done_d;
    logic [2:0]      lines_q, lines_d;
    logic [15:0]     total_q, total_d;
`ifdef GARBAGE_EN
    logic            top_out_q, top_out_d;
    logic            row0_occ;
`endif

    logic [ROWS-1:0] full_mask;
    logic [3:0]      probe_free;
    logic            src_found;
    logic [YW-1:0]   src_row;
    logic [CW-1:0]   src_data [COLS];
    logic [2:0]      pop_cnt;
    logic [16:0]     total_sum;

    assign lock_ready  = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign flash_row   = flash_row_q;
    assign done        = done_q;
    assign lines       = lines_q;
    assign total_lines = total_q;
`ifdef GARBAGE_EN
    assign top_out     = top_out_q;
`endif

    always_comb begin
        full_mask = '0;
        for (int r = 0; r < ROWS; r++) begin
            full_mask[r] = 1'b1;
            for (int c = 0; c < COLS; c++) begin
                if (cells_q[r][c] == '0) full_mask[r] = 1'b0;
            end
        end
    end

    // Out-of-range coordinates match no cell, so they read as 0 / not free.
    always_comb begin
        rd_color   = '0;
        probe_free = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (rd_y == YW'(r) && rd_x == XW'(c)) rd_color = cells_q[r][c];
                for (int k = 0; k < 4; k++) begin
                    if (probe_y[k*YW +: YW] == YW'(r) && probe_x[k*XW +: XW] == XW'(c) &&
                        cells_q[r][c] == '0)
                        probe_free[k] = 1'b1;
                end
            end
        end
        probe_ok = (&probe_free) && !busy;
    end

    // Nearest unflagged row at or above the source pointer; skips any run of cleared rows in one step.
    always_comb begin
        src_found = 1'b0;
        src_row   = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (YW'(r) <= src_q && !flash_row_q[r]) begin
                src_found = 1'b1;
                src_row   = YW'(r);
            end
        end
        for (int c = 0; c < COLS; c++) src_data[c] = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (src_row == YW'(r)) begin
                for (int c = 0; c < COLS; c++) src_data[c] = cells_q[r][c];
            end
        end
    end

    always_comb begin
        pop_cnt = '0;
        for (int r = 0; r < ROWS; r++) pop_cnt = pop_cnt + 3'(flash_row_q[r]);
        total_sum = {1'b0, total_q} + 17'(pop_cnt);
    end

`ifdef GARBAGE_EN
    always_comb begin
        row0_occ = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            if (cells_q[0][c] != '0) row0_occ = 1'b1;
        end
    end
`endif

    always_comb begin
        cells_d     = cells_q;
        state_d     = state_q;
        flash_row_d = flash_row_q;
        tick_cnt_d  = tick_cnt_q;
        dst_d       = dst_q;
        src_d       = src_q;
        src_end_d   = src_end_q;
        done_d      = 1'b0;
        lines_d     = lines_q;
        total_d     = total_q;
`ifdef GARBAGE_EN
        top_out_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (lock_valid) begin
                    for (int r = 0; r < ROWS; r++) begin
                        for (int c = 0; c < COLS; c++) begin
                            for (int k = 0; k < 4; k++) begin
                                if (lock_y[k*YW +: YW] == YW'(r) && lock_x[k*XW +: XW] == XW'(c))
                                    cells_d[r][c] = lock_color;
                            end
                        end
                    end
                    state_d = ST_SCAN;
                end
`ifdef GARBAGE_EN
                else if (garbage_valid) begin
                    for (int r = 0; r < ROWS - 1; r++) cells_d[r] = cells_q[r+1];
                    for (int c = 0; c < COLS; c++)
                        cells_d[ROWS-1][c] = (garbage_hole == XW'(c)) ? '0 : garbage_color;
                    done_d    = 1'b1;
                    lines_d   = '0;
                    top_out_d = row0_occ;
                end
`endif
            end
            ST_SCAN: begin
                flash_row_d = full_mask;
                tick_cnt_d  = '0;
                dst_d       = YW'(ROWS - 1);
                src_d       = YW'(ROWS - 1);
                src_end_d   = 1'b0;
                if (full_mask == '0) begin
                    done_d  = 1'b1;
                    lines_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLASH;
                end
            end
            ST_FLASH: begin
                if (frame_tick) begin
                    if (tick_cnt_q == 4'(FLASH_FRAMES - 1)) begin
                        tick_cnt_d = '0;
                        state_d    = ST_COMPACT;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 4'd1;
                    end
                end
            end
            ST_COMPACT: begin
                for (int r = 0; r < ROWS; r++) begin
                    if (dst_q == YW'(r)) begin
                        for (int c = 0; c < COLS; c++)
                            cells_d[r][c] = (src_found && !src_end_q) ? src_data[c] : '0;
                    end
                end
                if (src_found && !src_end_q && src_row != '0) src_d = src_row - YW'(1);
                else src_end_d = 1'b1;
                if (dst_q == '0) begin
                    done_d      = 1'b1;
                    lines_d     = pop_cnt;
                    total_d     = total_sum[16] ? 16'hFFFF : total_sum[15:0];
                    flash_row_d = '0;
                    state_d     = ST_IDLE;
                end else begin
                    dst_d = dst_q - YW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) cells_q[r][c] <= '0;
            end
            state_q     <= ST_IDLE;
            flash_row_q <= '0;
            tick_cnt_q  <= '0;
            dst_q       <= '0;
            src_q       <= '0;
            src_end_q   <= 1'b0;
            done_q      <= 1'b0;
            lines_q     <= '0;
            total_q     <= '0;
`ifdef GARBAGE_EN
            top_out_q   <= 1'b0;
`endif
        end else begin
            cells_q     <= cells_d;
            state_q     <= state_d;
            flash_row_q <= flash_row_d;
            tick_cnt_q  <= tick_cnt_d;
            dst_q       <= dst_d;
            src_q       <= src_d;
            src_end_q   <= src_end_d;
            done_q      <= done_d;
            lines_q     <= lines_d;
            total_q     <= total_d;
`ifdef GARBAGE_EN
            top_out_q   <= top_out_d;
`endif
        end
    end

endmodule
